// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the round-robin N:1 result mux.
// Optional build macro: MUX_RR_FIXED_PRIO_EN (fixed-priority arbitration).
package mux_pkg;

   localparam int DEF_NUM_SRC = 4;
   localparam int DEF_WIDTH   = 32;

   // Index width for n sources, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Defining MUX_RR_FIXED_PRIO_EN swaps in lowest-index-wins priority with no state.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int NUM_SRC = DEF_NUM_SRC,
   localparam int SEL_W   = clog2_min1(NUM_SRC)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_SRC-1:0] req,
   input  logic               en,
   output logic [NUM_SRC-1:0] grant,
   output logic [SEL_W-1:0]   grant_idx
);

`ifdef MUX_RR_FIXED_PRIO_EN

   logic found;
   logic unused_in;

   assign unused_in = ^{clk_i, rst_i, en};

   // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!found && req[i]) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = SEL_W'(i);
         end
      end
   end

`else

   logic [SEL_W-1:0] last_grant_q, last_grant_d;
   logic [SEL_W:0]   sum;
   logic [SEL_W-1:0] cand;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      // Walk from the slot after the last winner, wrapping modulo NUM_SRC.
      for (int i = 1; i <= NUM_SRC; i++) begin
         sum = {1'b0, last_grant_q} + (SEL_W+1)'(i);
         if (sum >= (SEL_W+1)'(NUM_SRC)) begin
            sum = sum - (SEL_W+1)'(NUM_SRC);
         end
         cand = sum[SEL_W-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (en && found) begin
         last_grant_d = grant_idx;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_grant_q <= SEL_W'(NUM_SRC - 1);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

`endif

endmodule : rr_arbiter

// File: rtl/mux_rr_nto1.sv
// N:1 valid/ready merge onto one registered output with the winning source index.
// Arbitration is round-robin unless MUX_RR_FIXED_PRIO_EN is defined.
module mux_rr_nto1
   import mux_pkg::*;
#(
   parameter  int NUM_SRC = DEF_NUM_SRC,
   parameter  int WIDTH   = DEF_WIDTH,
   localparam int SEL_W   = clog2_min1(NUM_SRC)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
   input  logic [NUM_SRC-1:0]       src_valid_i,
   output logic [NUM_SRC-1:0]       src_ready_o,
   output logic [WIDTH-1:0]         result_o,
   output logic                     result_valid_o,
   input  logic                     result_ready_i,
   output logic [SEL_W-1:0]         select_o
);

   logic [NUM_SRC-1:0] grant;
   logic [SEL_W-1:0]   grant_idx;
   logic               load_en;
   logic [WIDTH-1:0]   mux_data;

   logic [WIDTH-1:0]   result_q, result_d;
   logic               result_valid_q, result_valid_d;
   logic [SEL_W-1:0]   select_q, select_d;

   assign load_en = !result_valid_q || result_ready_i;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req       (src_valid_i),
      .en        (load_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // NOTE: ready is masked by the async reset itself, since load_en alone is high while reset holds valid low.
   assign src_ready_o = grant & {NUM_SRC{load_en && !rst_i}};

   // One-hot AND-OR select keeps the mux free of variable part-selects.
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         mux_data = mux_data | (src_data_i[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
      end
   end

   always_comb begin
      result_d       = result_q;
      select_d       = select_q;
      result_valid_d = result_valid_q;
      if (load_en) begin
         if (|src_valid_i) begin
            result_d       = mux_data;
            select_d       = grant_idx;
            result_valid_d = 1'b1;
         end else begin
            result_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_q       <= '0;
         select_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         result_q       <= result_d;
         select_q       <= select_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign result_o       = result_q;
   assign select_o       = select_q;
   assign result_valid_o = result_valid_q;

endmodule : mux_rr_nto1

// File: tb/tb_mux_rr_nto1.sv
// Directed bench for mux_rr_nto1 (NUM_SRC=4, WIDTH=32); follows MUX_RR_FIXED_PRIO_EN if defined.
module tb_mux_rr_nto1;

   localparam int NUM_SRC = 4;
   localparam int WIDTH   = 32;
   localparam int SEL_W   = 2;

`ifdef MUX_RR_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   logic                     clk_i = 1'b0;
   logic                     rst_i;
   logic [NUM_SRC*WIDTH-1:0] src_data_i;
   logic [NUM_SRC-1:0]       src_valid_i;
   logic [NUM_SRC-1:0]       src_ready_o;
   logic [WIDTH-1:0]         result_o;
   logic                     result_valid_o;
   logic                     result_ready_i;
   logic [SEL_W-1:0]         select_o;

   int n_vec = 0;
   int n_err = 0;

   mux_rr_nto1 #(
      .NUM_SRC (NUM_SRC),
      .WIDTH   (WIDTH)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .src_data_i     (src_data_i),
      .src_valid_i    (src_valid_i),
      .src_ready_o    (src_ready_o),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .select_o       (select_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_data(input int k, input logic [WIDTH-1:0] val);
      src_data_i[k*WIDTH +: WIDTH] = val;
   endtask

   initial begin
      rst_i          = 1'b1;
      src_valid_i    = '0;
      src_data_i     = '0;
      result_ready_i = 1'b1;

      // 1: reset, then idle
      @(negedge clk_i);
      src_valid_i = 4'b1111;
      #1 check("ready_in_reset", 32'(src_ready_o), 32'h0);
      src_valid_i = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst_valid", 32'(result_valid_o), 32'h0);
      check("rst_result", result_o, 32'h0);
      check("rst_select", 32'(select_o), 32'h0);
      check("rst_ready", 32'(src_ready_o), 32'h0);

      // 2: single source on ch2
      @(negedge clk_i);
      src_valid_i = 4'b0100;
      set_data(2, 32'hDEADBEEF);
      #1 check("single_ready", 32'(src_ready_o), 32'h4);
      @(negedge clk_i);
      src_valid_i = '0;
      check("single_result", result_o, 32'hDEADBEEF);
      check("single_select", 32'(select_o), 32'h2);
      check("single_valid", 32'(result_valid_o), 32'h1);

      // 3: all valid from a fresh pointer, eight back-to-back grants
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) set_data(k, 32'(16 + k));
      src_valid_i = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         check($sformatf("rr_select[%0d]", c), 32'(select_o), FIXED_PRIO ? 32'h0 : 32'(c % 4));
         check($sformatf("rr_result[%0d]", c), result_o, FIXED_PRIO ? 32'h10 : 32'(16 + c % 4));
      end

      // 4: backpressure with ch1 loaded
      src_valid_i = 4'b0010;
      set_data(1, 32'hA5);
      @(negedge clk_i);
      result_ready_i = 1'b0;
      src_valid_i    = 4'b1111;
      #1 check("bp_ready_entry", 32'(src_ready_o), 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         check($sformatf("bp_result[%0d]", c), result_o, 32'hA5);
         check($sformatf("bp_select[%0d]", c), 32'(select_o), 32'h1);
         check($sformatf("bp_valid[%0d]", c), 32'(result_valid_o), 32'h1);
         check($sformatf("bp_ready[%0d]", c), 32'(src_ready_o), 32'h0);
      end
      result_ready_i = 1'b1;
      #1 check("bp_release_ready", 32'(src_ready_o), FIXED_PRIO ? 32'h1 : 32'h4);
      @(negedge clk_i);
      check("bp_release_select", 32'(select_o), FIXED_PRIO ? 32'h0 : 32'h2);
      check("bp_release_result", result_o, FIXED_PRIO ? 32'h10 : 32'h12);

      // 5: ch3 then ch0, pointer wraps
      src_valid_i = 4'b1000;
      set_data(3, 32'h33);
      @(negedge clk_i);
      check("wrap_select3", 32'(select_o), 32'h3);
      check("wrap_result3", result_o, 32'h33);
      src_valid_i = 4'b0001;
      set_data(0, 32'h44);
      #1 check("wrap_ready0", 32'(src_ready_o), 32'h1);
      @(negedge clk_i);
      check("wrap_select0", 32'(select_o), 32'h0);
      check("wrap_result0", result_o, 32'h44);
      src_valid_i = 4'b1111;
      #1 check("wrap_next_ready", 32'(src_ready_o), FIXED_PRIO ? 32'h1 : 32'h2);

      // 6: asynchronous reset mid-cycle while output is valid
      #2 rst_i = 1'b1;
      #1;
      check("midrst_valid", 32'(result_valid_o), 32'h0);
      check("midrst_result", result_o, 32'h0);
      check("midrst_select", 32'(select_o), 32'h0);
      check("midrst_ready", 32'(src_ready_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1 check("postrst_ready", 32'(src_ready_o), 32'h1);
      @(negedge clk_i);
      check("postrst_select", 32'(select_o), 32'h0);
      check("postrst_result", result_o, 32'h44);
      check("postrst_valid", 32'(result_valid_o), 32'h1);

      // Load with no requester: valid drops, data and index hold
      src_valid_i = '0;
      @(negedge clk_i);
      check("idle_valid", 32'(result_valid_o), 32'h0);
      check("idle_result", result_o, 32'h44);
      check("idle_select", 32'(select_o), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mux_rr_nto1
